usb_nrzi_encoder: RTL and testbench
===================================

// Module: usb_nrzi_encoder
// PURPOSE
//  TX line stage directly downstream of the USB bit stuffer. Consumes stuffed bits one per clk (clk = bit clock).
//  NRZI-encodes them (0 = toggle, 1 = hold) onto differential dp/dm with output enable, and appends the EOP (SE0 then J).
//  Optionally generates the SYNC field itself.
// PARAMETERS
//  LOW_SPEED     0  0: J = {dp,dm}=2'b10 (full speed); 1: J = 2'b01 (low speed); K = inverse of J
//  EOP_SE0_BITS  2  SE0 bit times in EOP, >=1
//  EOP_J_BITS    1  J bit times after SE0 before oe drops, >=1
// PORTS
//  clk        in   1  bit clock
//  nRST       in   1  asynchronous, active-low reset
//  tx_start   in   1  pulse: begin packet (accepted only in IDLE)
//  in_bit     in   1  data bit from stuffer, LSB-first order already applied
//  in_valid   in   1  in_bit valid; consumed when in_valid && in_ready
//  in_ready   out  1  = (state==ACTIVE) && !in_stuff (combinational)
//  in_stuff   in   1  stuffed-zero slot: transmit a 0 this bit time
//  eop_req    in   1  last bit of packet is presented this cycle (or already sent); start EOP
//  dp, dm     out  1  line state, registered
//  oe         out  1  transceiver output enable, registered
//  busy       out  1  state != IDLE
//  eop_done   out  1  one-cycle pulse when final J bit time ends
//  underrun   out  1  sticky: ACTIVE cycle with no bit, no stuff, no eop_req; cleared on accepted tx_start
// BEHAVIOUR
//  - Reset (async): state IDLE, lvl=J, {dp,dm}=J, oe=0, eop_done=0, underrun=0, counters 0.
//  - FSM: IDLE -> SYNC (macro on) or ACTIVE (macro off) on tx_start; SYNC -> ACTIVE after 8 bits;
//    ACTIVE -> EOP_SE0 on eop_req; EOP_SE0 -> EOP_J after EOP_SE0_BITS; EOP_J -> IDLE after EOP_J_BITS.
//  - NRZI register lvl (J/K). Each bit time in SYNC/ACTIVE: bit 0 toggles lvl, bit 1 holds; {dp,dm}<=new lvl.
//    Latency in_bit -> dp/dm: 1 clk.
//  - ACTIVE priority: in_stuff (send 0, in_valid ignored, in_ready=0) > in_valid (send in_bit) > hold line.
//    Hold line without eop_req sets underrun.
//  - eop_req with a bit in the same cycle: bit encoded that edge; SE0 starts next edge. in_ready=0 from then on.
//  - EOP_SE0: {dp,dm}=2'b00, oe=1. EOP_J: {dp,dm}=J, oe=1.
//    On the last EOP_J edge: oe<=0, {dp,dm}<=J, lvl<=J, eop_done<=1 for one cycle.
//  - oe<=1 on the edge that leaves IDLE.
//    Macro off: first ACTIVE bit time, if empty, shows J without raising underrun, i.e. the first ACTIVE cycle is exempt.
//  - Ignored inputs: tx_start outside IDLE; eop_req outside ACTIVE; in_valid/in_stuff outside ACTIVE.
//  - Counter width $clog2(max(8,EOP_SE0_BITS,EOP_J_BITS)+1); no wrap reachable.
//  - nRST mid-packet: line returns to J with oe=0 immediately; no eop_done pulse.
// CONFIGURATION
//  USB_NRZI_SYNC_EN defined:
//    tx_start enters SYNC and emits 8'h80 LSB-first (K J K J K J K K) with in_ready=0, then ACTIVE.
//  USB_NRZI_SYNC_EN undefined:
//    SYNC state and counter absent; tx_start enters ACTIVE directly; upstream supplies SYNC as data.
// STRUCTURE
//  usb_pkg: line_state_t enum {LS_SE0, LS_J, LS_K}, nrzi_state_t enum, USB_SYNC_PATTERN = 8'h80.
//  Sub-module usb_line_driver: combinational line_state_t + LOW_SPEED -> {dp,dm}; top registers its output.
// TESTING
//  1. Reset, idle 5 clk -> dp=1, dm=0, oe=0, busy=0, in_ready=0.
//  2. SYNC_EN, tx_start, data 8'hA5 LSB-first, eop_req on last bit
//     -> 8 sync bit times K J K J K J K K, then data line states per NRZI,
//     then 2 SE0, 1 J, oe falls, eop_done pulses once.
//  3. in_stuff asserted together with in_valid in ACTIVE -> line toggles; in_ready=0; in_bit held, accepted next cycle.
//  4. ACTIVE, one idle cycle (no valid/stuff/eop) -> line unchanged, underrun=1 until next tx_start.
//  5. LOW_SPEED=1, EOP_SE0_BITS=3 -> idle {dp,dm}=01, EOP shows 3 SE0 then 01.
//  6. nRST pulse during EOP_SE0 -> same cycle oe=0, {dp,dm}=J, busy=0; later tx_start restarts normally.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types and constants for the USB TX line stage (NRZI encoder and line driver).
package usb_pkg;

  typedef enum logic [1:0] {LS_SE0, LS_J, LS_K} line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACTIVE,
    ST_EOP_SE0,
    ST_EOP_J
  } nrzi_state_t;

  localparam logic [7:0] USB_SYNC_PATTERN = 8'h80;

  function automatic line_state_t nrzi_toggle(input line_state_t ls);
    return (ls == LS_J) ? LS_K : LS_J;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usb_line_driver.sv
// Maps a symbolic line state onto the {dp,dm} pair; J/K polarity follows the bus speed.
module usb_line_driver
  import usb_pkg::*;
#(
  parameter int LOW_SPEED = 0
) (
  input  line_state_t ls,
  output logic [1:0]  pair
);

  always_comb begin
    pair = 2'b00;
    case (ls)
      LS_J:    pair = (LOW_SPEED != 0) ? 2'b01 : 2'b10;
      LS_K:    pair = (LOW_SPEED != 0) ? 2'b10 : 2'b01;
      default: pair = 2'b00;
    endcase
  end

endmodule

// File: rtl/usb_nrzi_encoder.sv
// NRZI line encoder with EOP generation; one stuffed bit per clk, 1 clk from in_bit to dp/dm.
// Define USB_NRZI_SYNC_EN to have the block emit the SYNC field itself after tx_start.
module usb_nrzi_encoder
  import usb_pkg::*;
#(
  parameter int LOW_SPEED    = 0,
  parameter int EOP_SE0_BITS = 2,
  parameter int EOP_J_BITS   = 1
) (
  input  logic clk,
  input  logic nRST,
  input  logic tx_start,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_stuff,
  input  logic eop_req,
  output logic dp,
  output logic dm,
  output logic oe,
  output logic busy,
  output logic eop_done,
  output logic underrun
);

  localparam int CNT_W = $clog2(max3(8, EOP_SE0_BITS, EOP_J_BITS) + 1);
  localparam logic [CNT_W-1:0] SE0_LAST = CNT_W'(EOP_SE0_BITS - 1);
  localparam logic [CNT_W-1:0] J_LAST   = CNT_W'(EOP_J_BITS);
  localparam logic [1:0] J_PAIR = (LOW_SPEED != 0) ? 2'b01 : 2'b10;

  nrzi_state_t      state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  line_state_t      lvl, nxt_lvl, nxt_ls;
  logic             nxt_oe, nxt_eop_done, nxt_underrun;
  logic             bit_en, bit_val, exempt;
  logic [1:0]       nxt_pair;

  assign busy     = (state != ST_IDLE);
  assign in_ready = (state == ST_ACTIVE) && !in_stuff;

`ifdef USB_NRZI_SYNC_EN
  assign exempt = 1'b0;
`else
  // Upstream cannot have a bit ready on the very first ACTIVE cycle, so that gap is not an underrun.
  logic first_q;
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) first_q <= 1'b0;
    else       first_q <= (state == ST_IDLE) && tx_start;
  end
  assign exempt = first_q;
`endif

  always_comb begin
    nxt_state    = state;
    nxt_cnt      = cnt;
    nxt_lvl      = lvl;
    nxt_ls       = lvl;
    nxt_oe       = oe;
    nxt_eop_done = 1'b0;
    nxt_underrun = underrun;
    bit_en       = 1'b0;
    bit_val      = 1'b1;
    case (state)
      ST_IDLE: begin
        if (tx_start) begin
          nxt_oe       = 1'b1;
          nxt_underrun = 1'b0;
          nxt_cnt      = '0;
`ifdef USB_NRZI_SYNC_EN
          nxt_state    = ST_SYNC;
`else
          nxt_state    = ST_ACTIVE;
`endif
        end
      end
`ifdef USB_NRZI_SYNC_EN
      ST_SYNC: begin
        bit_en  = 1'b1;
        bit_val = USB_SYNC_PATTERN[cnt[2:0]];
        nxt_cnt = cnt + 1'b1;
        if (cnt == CNT_W'(7)) begin
          nxt_state = ST_ACTIVE;
          nxt_cnt   = '0;
        end
      end
`endif
      ST_ACTIVE: begin
        if (in_stuff) begin
          bit_en  = 1'b1;
          bit_val = 1'b0;
        end else if (in_valid) begin
          bit_en  = 1'b1;
          bit_val = in_bit;
        end else if (!eop_req && !exempt) begin
          nxt_underrun = 1'b1;
        end
        if (eop_req) begin
          nxt_state = ST_EOP_SE0;
          nxt_cnt   = '0;
        end
      end
      ST_EOP_SE0: begin
        nxt_ls  = LS_SE0;
        nxt_cnt = cnt + 1'b1;
        if (cnt == SE0_LAST) begin
          nxt_state = ST_EOP_J;
          nxt_cnt   = '0;
        end
      end
      ST_EOP_J: begin
        // EOP_J_BITS edges drive J with oe high; the following edge releases the bus.
        nxt_ls  = LS_J;
        nxt_cnt = cnt + 1'b1;
        if (cnt == J_LAST) begin
          nxt_state    = ST_IDLE;
          nxt_cnt      = '0;
          nxt_oe       = 1'b0;
          nxt_lvl      = LS_J;
          nxt_eop_done = 1'b1;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
    if (bit_en) begin
      nxt_lvl = bit_val ? lvl : nrzi_toggle(lvl);
      nxt_ls  = nxt_lvl;
    end
  end

  usb_line_driver #(.LOW_SPEED(LOW_SPEED)) u_drv (
    .ls   (nxt_ls),
    .pair (nxt_pair)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lvl      <= LS_J;
      {dp, dm} <= J_PAIR;
      oe       <= 1'b0;
      eop_done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      lvl      <= nxt_lvl;
      {dp, dm} <= nxt_pair;
      oe       <= nxt_oe;
      eop_done <= nxt_eop_done;
      underrun <= nxt_underrun;
    end
  end

endmodule

// File: tb/tb_usb_nrzi_encoder.sv
// Bench for usb_nrzi_encoder: directed rows push expected outputs, a negedge monitor pops and compares.
module tb_usb_nrzi_encoder;

  localparam logic [1:0] FJ = 2'b10, FK = 2'b01, LJ = 2'b01, LK = 2'b10;
`ifdef USB_NRZI_SYNC_EN
  localparam logic SYNC_BY_DATA = 1'b0;
`else
  localparam logic SYNC_BY_DATA = 1'b1;
`endif

  typedef struct {
    int         cyc;
    int         dut;
    logic [6:0] v;
    string      nm;
  } exp_t;

  logic clk = 1'b0;
  logic nRST;
  logic [1:0] ts, iv, ib, is, er;
  logic dp_a, dm_a, oe_a, busy_a, done_a, und_a, rdy_a;
  logic dp_b, dm_b, oe_b, busy_b, done_b, und_b, rdy_b;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic end_chk = 1'b0;
  logic end_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_nrzi_encoder u_fs (
    .clk(clk), .nRST(nRST), .tx_start(ts[0]), .in_bit(ib[0]), .in_valid(iv[0]),
    .in_ready(rdy_a), .in_stuff(is[0]), .eop_req(er[0]), .dp(dp_a), .dm(dm_a),
    .oe(oe_a), .busy(busy_a), .eop_done(done_a), .underrun(und_a)
  );

  usb_nrzi_encoder #(.LOW_SPEED(1), .EOP_SE0_BITS(3), .EOP_J_BITS(1)) u_ls (
    .clk(clk), .nRST(nRST), .tx_start(ts[1]), .in_bit(ib[1]), .in_valid(iv[1]),
    .in_ready(rdy_b), .in_stuff(is[1]), .eop_req(er[1]), .dp(dp_b), .dm(dm_b),
    .oe(oe_b), .busy(busy_b), .eop_done(done_b), .underrun(und_b)
  );

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [6:0] got;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      got = (e.dut == 0) ? {dp_a, dm_a, oe_a, busy_a, done_a, und_a, rdy_a}
                         : {dp_b, dm_b, oe_b, busy_b, done_b, und_b, rdy_b};
      total++;
      if (e.cyc != cyc || got !== e.v) begin
        bad++;
        $display("FAIL %s cyc=%0d dut=%0d {dp,dm,oe,busy,done,underrun,ready} got=%b want=%b (due cyc %0d)",
                 e.nm, cyc, e.dut, got, e.v, e.cyc);
      end
    end
    if (end_chk && !end_done) begin
      end_done = 1'b1;
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL leftover_expectations got=%0d want=0", q.size());
      end
    end
  end

  // One bit time: drive the inputs for this cycle and queue what the monitor must see in it.
  task automatic row(input int d, input logic t, input logic v, input logic b, input logic s,
                     input logic e, input logic [1:0] pr, input logic o, input logic bz,
                     input logic dn, input logic un, input logic rd, input string nm);
    exp_t x;
    ts = '0; iv = '0; ib = '0; is = '0; er = '0;
    ts[d] = t; iv[d] = v; ib[d] = b; is[d] = s; er[d] = e;
    x.cyc = cyc;
    x.dut = d;
    x.v   = {pr, o, bz, dn, un, rd};
    x.nm  = nm;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // tx_start plus the eight SYNC bit times (K J K J K J K K on the line, one cycle late).
  task automatic sync_rows(input int d, input logic [1:0] jc, input logic [1:0] kc, input logic und_first);
    logic [7:0] pat = 8'h80;
    logic [7:0] kmask = 8'b1010_1010;
    row(d, 1, 0, 0, 0, 0, jc, 0, 0, 0, und_first, 0, "sync_start");
    for (int i = 0; i < 8; i++)
      row(d, 0, SYNC_BY_DATA, pat[i], 0, 0, kmask[i] ? kc : jc, 1, 1, 0, 0, SYNC_BY_DATA, "sync_bit");
  endtask

  // Rows following the eop_req cycle: last bit, n SE0, J with oe, then release and done pulse.
  task automatic eop_rows(input int d, input logic [1:0] jc, input logic [1:0] last, input int n_se0,
                          input logic un);
    row(d, 0, 0, 0, 0, 0, last, 1, 1, 0, un, 0, "eop_last_bit");
    for (int i = 0; i < n_se0; i++)
      row(d, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, un, 0, "eop_se0");
    row(d, 0, 0, 0, 0, 0, jc, 1, 1, 0, un, 0, "eop_j");
    row(d, 0, 0, 0, 0, 0, jc, 0, 0, 1, un, 0, "eop_done");
    row(d, 0, 0, 0, 0, 0, jc, 0, 0, 0, un, 0, "after_eop");
  endtask

  initial begin
    logic [7:0] dat = 8'hA5;
    logic [7:0] kobs = 8'h93;
    nRST = 1'b0;
    ts = '0; iv = '0; ib = '0; is = '0; er = '0;
    @(posedge clk);
    #1;
    row(0, 0, 0, 0, 0, 0, FJ, 0, 0, 0, 0, 0, "reset_fs");
    row(1, 0, 0, 0, 0, 0, LJ, 0, 0, 0, 0, 0, "reset_ls");
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) row(0, 0, 0, 0, 0, 0, FJ, 0, 0, 0, 0, 0, "idle");

    // SYNC then 8'hA5 LSB-first, eop_req with the last bit
    sync_rows(0, FJ, FK, 0);
    for (int i = 0; i < 8; i++)
      row(0, 0, 1, dat[i], 0, (i == 7), kobs[i] ? FK : FJ, 1, 1, 0, 0, 1, "data_a5");
    eop_rows(0, FJ, FK, 2, 0);

    // stuffed zero overrides a pending data bit, which is taken the next cycle
    sync_rows(0, FJ, FK, 0);
    row(0, 0, 1, 1, 1, 0, FK, 1, 1, 0, 0, 0, "stuff_slot");
    row(0, 0, 1, 1, 0, 0, FJ, 1, 1, 0, 0, 1, "stuff_toggled");
    row(0, 0, 1, 0, 0, 1, FJ, 1, 1, 0, 0, 1, "held_bit_taken");
    eop_rows(0, FJ, FK, 2, 0);

    // one empty ACTIVE cycle: line holds, underrun sticks until the next tx_start
    sync_rows(0, FJ, FK, 0);
    row(0, 0, 1, 0, 0, 0, FK, 1, 1, 0, 0, 1, "pre_gap");
    row(0, 0, 0, 0, 0, 0, FJ, 1, 1, 0, 0, 1, "gap");
    row(0, 0, 1, 1, 0, 1, FJ, 1, 1, 0, 1, 1, "underrun_set");
    eop_rows(0, FJ, FJ, 2, 1);

    // reset asserted in EOP_SE0, then a clean restart
    sync_rows(0, FJ, FK, 1);
    row(0, 0, 1, 1, 0, 1, FK, 1, 1, 0, 0, 1, "last_bit");
    row(0, 0, 0, 0, 0, 0, FK, 1, 1, 0, 0, 0, "se0_first");
    nRST = 1'b0;
    row(0, 0, 0, 0, 0, 0, FJ, 0, 0, 0, 0, 0, "rst_in_eop");
    nRST = 1'b1;
    row(0, 0, 0, 0, 0, 0, FJ, 0, 0, 0, 0, 0, "post_rst");
    row(0, 0, 0, 0, 0, 0, FJ, 0, 0, 0, 0, 0, "post_rst_no_done");
    sync_rows(0, FJ, FK, 0);
    row(0, 0, 1, 0, 0, 1, FK, 1, 1, 0, 0, 1, "restart_bit");
    eop_rows(0, FJ, FJ, 2, 0);

    // low-speed instance, three SE0 bit times
    row(1, 0, 0, 0, 0, 0, LJ, 0, 0, 0, 0, 0, "idle_ls");
    sync_rows(1, LJ, LK, 0);
    row(1, 0, 1, 1, 0, 1, LK, 1, 1, 0, 0, 1, "last_bit_ls");
    eop_rows(1, LJ, LK, 3, 0);

    end_chk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
